// File: rtl/ripple_count_extender.sv
// Registers the 2-bit ripple counter output once per Clk, checks its sequence and
// widens it to WIDTH bits by counting 11->00 wraps; adds compare match and a snapshot port.
module ripple_count_extender #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic [1:0]       Count_in,
    input  logic [WIDTH-1:0] cmp_value,
    input  logic             clr_flags,
    input  logic             snap_req,
    input  logic             snap_ack,
    output logic [WIDTH-1:0] count_out,
    output logic             count_valid,
    output logic             wrap_pulse,
    output logic             match,
    output logic             seq_err,
    output logic             ovf,
    output logic             snap_valid,
    output logic [WIDTH-1:0] snap_data
);

    localparam int HW = WIDTH - 2;

    typedef enum logic {
        IDLE,
        HOLD
    } snap_st_t;

    logic [1:0]       cnt_s;
    logic [HW-1:0]    ext_hi;
    logic             primed;

    logic [1:0]       cnt_inc;
    logic             is_wrap;
    logic             is_bad;
    logic             ext_ovf;
    logic [HW-1:0]    ext_nxt;
    logic [WIDTH-1:0] count_nxt;

    snap_st_t         st, st_nxt;
    logic             snap_load;

    // The first sample after reset is only a baseline: no check, no wrap.
    always_comb begin
        cnt_inc   = cnt_s + 2'd1;
        is_wrap   = primed && (cnt_s == 2'b11) && (Count_in == 2'b00);
        is_bad    = primed && (Count_in != cnt_inc);
        ext_ovf   = is_wrap && (&ext_hi);
        ext_nxt   = is_wrap ? ext_hi + HW'(1) : ext_hi;
        count_nxt = {ext_nxt, Count_in};
    end

    assign count_out = {ext_hi, cnt_s};

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            cnt_s       <= '0;
            ext_hi      <= '0;
            primed      <= 1'b0;
            count_valid <= 1'b0;
            wrap_pulse  <= 1'b0;
            match       <= 1'b0;
            seq_err     <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            cnt_s       <= Count_in;
            ext_hi      <= ext_nxt;
            primed      <= 1'b1;
            count_valid <= 1'b1;
            wrap_pulse  <= is_wrap;
            // count_valid is always 1 after any non-reset edge, so match tracks the new count.
            match       <= (count_nxt == cmp_value);
            seq_err     <= is_bad  | (seq_err & ~clr_flags);
            ovf         <= ext_ovf | (ovf & ~clr_flags);
        end
    end

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) st <= IDLE;
        else     st <= st_nxt;
    end

    always_comb begin
        st_nxt    = st;
        snap_load = 1'b0;
        case (st)
            IDLE: if (snap_req && count_valid) begin
                snap_load = 1'b1;
                st_nxt    = HOLD;
            end
            HOLD: if (snap_ack) st_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge rst) begin
        if (rst)            snap_data <= '0;
        else if (snap_load) snap_data <= count_out;
    end

    assign snap_valid = (st == HOLD);

endmodule

// File: tb/tb_ripple_count_extender.sv
// Drives an 8-bit and a 4-bit extender from one emulated ripple counter and checks
// every cycle against a scoreboard of expected outputs.
module tb_ripple_count_extender;

    logic       Clk = 1'b0;
    logic       rst;
    logic [1:0] Count_in;
    logic [7:0] cmp8;
    logic [3:0] cmp4;
    logic       clr_flags, snap_req, snap_ack;

    logic [7:0] c8, sd8;
    logic [3:0] c4, sd4;
    logic       cv8, wp8, m8, se8, o8, sv8;
    logic       cv4, wp4, m4, se4, o4, sv4;

    always #5 Clk = ~Clk;

    ripple_count_extender #(.WIDTH(8)) dut8 (
        .Clk(Clk), .rst(rst), .Count_in(Count_in), .cmp_value(cmp8),
        .clr_flags(clr_flags), .snap_req(snap_req), .snap_ack(snap_ack),
        .count_out(c8), .count_valid(cv8), .wrap_pulse(wp8), .match(m8),
        .seq_err(se8), .ovf(o8), .snap_valid(sv8), .snap_data(sd8)
    );

    ripple_count_extender #(.WIDTH(4)) dut4 (
        .Clk(Clk), .rst(rst), .Count_in(Count_in), .cmp_value(cmp4),
        .clr_flags(clr_flags), .snap_req(snap_req), .snap_ack(snap_ack),
        .count_out(c4), .count_valid(cv4), .wrap_pulse(wp4), .match(m4),
        .seq_err(se4), .ovf(o4), .snap_valid(sv4), .snap_data(sd4)
    );

    typedef struct {
        logic [7:0] c8;
        logic [3:0] c4;
        logic       cv, wp, se, m8, m4, o8, o4, sv8, sv4;
        logic [7:0] sd8;
        logic [3:0] sd4;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int hits8  = 0;

    // Reference model: unbounded count, low 2 bits follow the input.
    logic [31:0] m_full;
    logic        m_primed, m_seq, m_o8, m_o4, m_h8, m_h4;
    logic [7:0]  m_sd8;
    logic [3:0]  m_sd4;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_full = '0; m_primed = 1'b0; m_seq = 1'b0; m_o8 = 1'b0; m_o4 = 1'b0;
        m_h8 = 1'b0; m_h4 = 1'b0; m_sd8 = '0; m_sd4 = '0;
    endtask

    task automatic model_edge(input logic [1:0] cin, input logic req, input logic ack, input logic clr);
        exp_t e;
        logic wrap, bad, s8, s4;
        logic [1:0] nx;
        if (!m_h8) begin
            if (req && m_primed) begin m_sd8 = m_full[7:0]; m_h8 = 1'b1; end
        end else if (ack) m_h8 = 1'b0;
        if (!m_h4) begin
            if (req && m_primed) begin m_sd4 = m_full[3:0]; m_h4 = 1'b1; end
        end else if (ack) m_h4 = 1'b0;
        nx   = m_full[1:0] + 2'd1;
        wrap = m_primed && (m_full[1:0] == 2'd3) && (cin == 2'd0);
        bad  = m_primed && (cin != nx);
        s8   = wrap && (m_full[7:2] == 6'h3f);
        s4   = wrap && (m_full[3:2] == 2'h3);
        m_seq = bad | (m_seq & ~clr);
        m_o8  = s8 | (m_o8 & ~clr);
        m_o4  = s4 | (m_o4 & ~clr);
        if (wrap) m_full = (m_full & ~32'd3) + 32'd4;
        else      m_full = (m_full & ~32'd3) | {30'd0, cin};
        m_primed = 1'b1;
        e.c8 = m_full[7:0];  e.c4 = m_full[3:0];
        e.cv = 1'b1;         e.wp = wrap;  e.se = m_seq;
        e.m8 = (m_full[7:0] == cmp8);
        e.m4 = (m_full[3:0] == cmp4);
        e.o8 = m_o8;  e.o4 = m_o4;
        e.sv8 = m_h8; e.sv4 = m_h4; e.sd8 = m_sd8; e.sd4 = m_sd4;
        q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (q.size() == 0) return;
        e = q.pop_front();
        chk("count_out8",  32'(c8),  32'(e.c8));
        chk("count_out4",  32'(c4),  32'(e.c4));
        chk("count_valid8", 32'(cv8), 32'(e.cv));
        chk("count_valid4", 32'(cv4), 32'(e.cv));
        chk("wrap_pulse8", 32'(wp8), 32'(e.wp));
        chk("wrap_pulse4", 32'(wp4), 32'(e.wp));
        chk("match8",      32'(m8),  32'(e.m8));
        chk("match4",      32'(m4),  32'(e.m4));
        chk("seq_err8",    32'(se8), 32'(e.se));
        chk("seq_err4",    32'(se4), 32'(e.se));
        chk("ovf8",        32'(o8),  32'(e.o8));
        chk("ovf4",        32'(o4),  32'(e.o4));
        chk("snap_valid8", 32'(sv8), 32'(e.sv8));
        chk("snap_valid4", 32'(sv4), 32'(e.sv4));
        chk("snap_data8",  32'(sd8), 32'(e.sd8));
        chk("snap_data4",  32'(sd4), 32'(e.sd4));
        if (m8 === 1'b1) hits8++;
    endtask

    // Called at a negedge: check the previous edge, drive new inputs, predict the next edge.
    task automatic step(input logic [1:0] cin, input logic req, input logic ack, input logic clr);
        pop_check();
        Count_in  = cin;
        snap_req  = req;
        snap_ack  = ack;
        clr_flags = clr;
        model_edge(cin, req, ack, clr);
        @(negedge Clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_count_out8"}, 32'(c8), 32'd0);
        chk({tag, "_count_out4"}, 32'(c4), 32'd0);
        chk({tag, "_ctl8"}, 32'({cv8, wp8, m8, se8, o8, sv8}), 32'd0);
        chk({tag, "_ctl4"}, 32'({cv4, wp4, m4, se4, o4, sv4}), 32'd0);
        chk({tag, "_snap_data8"}, 32'(sd8), 32'd0);
        chk({tag, "_snap_data4"}, 32'(sd4), 32'd0);
    endtask

    initial begin
        rst = 1'b1; Count_in = 2'd0; cmp8 = 8'd6; cmp4 = 4'd6;
        clr_flags = 1'b0; snap_req = 1'b0; snap_ack = 1'b0;
        model_reset();
        #1;
        check_all_zero("reset");
        @(negedge Clk);
        rst = 1'b0;

        // Free run: first sample is 1; snapshot at 9, ack, re-request held over an ack;
        // 4-bit overflow at 16 cleared at 18, 8-bit overflow at 256.
        hits8 = 0;
        for (int i = 1; i <= 300; i++)
            step(2'(i % 4), (i == 10) || (i >= 20 && i <= 26),
                 (i == 16) || (i == 23) || (i == 30), i == 18);
        chk("match8_hits", 32'(hits8), 32'd2);

        // Skip 01->11: sticky seq_err, no wrap; the following 11->00 still extends.
        step(2'd1, 1'b0, 1'b0, 1'b0);
        step(2'd3, 1'b0, 1'b0, 1'b0);
        step(2'd0, 1'b0, 1'b0, 1'b0);
        step(2'd1, 1'b1, 1'b0, 1'b0);
        step(2'd2, 1'b0, 1'b0, 1'b0);
        pop_check();
        chk("pre_rst_seq_err", 32'(se8), 32'd1);
        chk("pre_rst_hold", 32'(sv8), 32'd1);

        // Reset during HOLD: immediate clear, then a jump to 00 is only a baseline.
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        q.delete();
        model_reset();
        @(negedge Clk);
        rst = 1'b0;
        step(2'd0, 1'b0, 1'b0, 1'b0);
        step(2'd1, 1'b0, 1'b0, 1'b0);
        step(2'd2, 1'b0, 1'b0, 1'b0);
        step(2'd3, 1'b0, 1'b0, 1'b0);
        step(2'd0, 1'b0, 1'b0, 1'b0);
        pop_check();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
